ext_mem_bridge: RTL and testbench

- Bus master that carries the core's 16-bit memory transactions onto the chip's 8-bit pin interface.
- Serialises the address and write data outward in byte beats, and reassembles read data from byte beats.
- Sits between the core's load/store path (replaces the tied-zero data-memory output) and the uo_out/uio pins.
- One request in flight at a time; per-beat ack handshake with an optional timeout.

---
 rtl/ext_mem_bridge.sv | 151 +++++++++++++++
 tb/tb_ext_mem_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bridge.sv
// Byte-serial bus master: carries one 16-bit core memory request at a time over an 8-bit strobe/ack pin bus.
// Optional per-beat ack timeout enabled by defining BRIDGE_TIMEOUT_EN.
module ext_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    input  logic [7:0]  bus_in,
    output logic [1:0]  bus_ctl,
    output logic        bus_strb,
    input  logic        bus_ack
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("ext_mem_bridge: TIMEOUT_CYCLES out of range for TIMEOUT_W");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  rd_hi_q;
    logic [15:0] addr_src;
    logic [1:0]  ctl_next;
    logic [7:0]  out_next;
    logic        ack_beat;
    logic        timeout_hit;

    // bus_strb is registered from the state, so it doubles as the "in a beat" flag.
    assign ack_beat = bus_strb && bus_ack;

`ifdef BRIDGE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 err_q;

    // An ack in the final allowed cycle still completes the beat.
    assign timeout_hit = bus_strb && !bus_ack && (wait_cnt == WAIT_LAST);
    assign rsp_err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (bus_strb) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ADDR_HI;
            ADDR_HI: if (ack_beat)  state_next = ADDR_LO;
            ADDR_LO: if (ack_beat)  state_next = we_q ? WR_HI : RD_HI;
            WR_HI:   if (ack_beat)  state_next = WR_LO;
            WR_LO:   if (ack_beat)  state_next = RESP;
            RD_HI:   if (ack_beat)  state_next = RD_LO;
            RD_LO:   if (ack_beat)  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = RESP;
        end
    end

    // The address is latched on the same edge that enters ADDR_HI, so take it from the port then.
    always_comb begin
        addr_src = (state == IDLE) ? req_addr : addr_q;
        ctl_next = 2'b00;
        out_next = 8'h00;
        case (state_next)
            ADDR_HI: begin ctl_next = 2'b01; out_next = addr_src[15:8]; end
            ADDR_LO: begin ctl_next = 2'b01; out_next = addr_q[7:0];    end
            WR_HI:   begin ctl_next = 2'b10; out_next = wdata_q[15:8];  end
            WR_LO:   begin ctl_next = 2'b10; out_next = wdata_q[7:0];   end
            RD_HI:   ctl_next = 2'b11;
            RD_LO:   ctl_next = 2'b11;
            default: ctl_next = 2'b00;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            bus_out   <= 8'h00;
            bus_oe    <= 8'h00;
            bus_ctl   <= 2'b00;
            bus_strb  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rd_hi_q   <= 8'h00;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RESP);
            bus_strb  <= (ctl_next != 2'b00);
            bus_ctl   <= ctl_next;
            bus_out   <= out_next;
            bus_oe    <= (ctl_next == 2'b01 || ctl_next == 2'b10) ? 8'hFF : 8'h00;

            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD_HI && ack_beat) begin
                rd_hi_q <= bus_in;
            end
            if (timeout_hit) begin
                rsp_rdata <= 16'h0000;
            end else if (state == RD_LO && ack_beat) begin
                rsp_rdata <= {rd_hi_q, bus_in};
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Self-checking bench for ext_mem_bridge: directed plus randomized transactions against a beat-level model.
// Timeout scenarios run only when BRIDGE_TIMEOUT_EN is defined.
module tb_ext_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic [7:0]  bus_in;
    logic [1:0]  bus_ctl;
    logic        bus_strb;
    logic        bus_ack;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] prev_rdata = 16'h0000;

    ext_mem_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in),
        .bus_ctl   (bus_ctl),
        .bus_strb  (bus_strb),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {strb, ctl, oe, out} while a beat of the given type is on the pins.
    function automatic logic [18:0] beat_exp(input logic [1:0] ctl, input logic [7:0] b);
        logic outbound;
        outbound = (ctl != 2'b11);
        return {1'b1, ctl, outbound ? 8'hFF : 8'h00, outbound ? b : 8'h00};
    endfunction

    // One full transaction; waits[b] idle cycles precede the ack of beat b.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int w0, input int w1, input int w2, input int w3,
                           input logic [7:0] rd_hi, input logic [7:0] rd_lo);
        int          waits[4];
        logic [1:0]  ctl[4];
        logic [7:0]  byt[4];
        logic [15:0] exp_rdata;
        waits = '{w0, w1, w2, w3};
        ctl   = '{2'b01, 2'b01, we ? 2'b10 : 2'b11, we ? 2'b10 : 2'b11};
        byt   = '{addr[15:8], addr[7:0], wdata[15:8], wdata[7:0]};

        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        bus_ack   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w <= waits[b]; w++) begin
                check($sformatf("beat%0d_w%0d", b, w), {13'd0, bus_strb, bus_ctl, bus_oe, bus_out},
                      {13'd0, beat_exp(ctl[b], byt[b])});
                bus_ack = (w == waits[b]);
                if (w == waits[b] && b == 2)      bus_in = rd_hi;
                else if (w == waits[b] && b == 3) bus_in = rd_lo;
                else                              bus_in = 8'($urandom);
                @(negedge clk);
            end
        end
        bus_ack   = 1'b0;
        exp_rdata = we ? prev_rdata : {rd_hi, rd_lo};
        check("resp", {rsp_valid, rsp_err, bus_strb, bus_oe, 5'd0, rsp_rdata},
              {1'b1, 1'b0, 1'b0, 8'h00, 5'd0, exp_rdata});
        prev_rdata = exp_rdata;
        @(negedge clk);
        check("after_resp", {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        bus_in    = 8'h00;
        bus_ack   = 1'b0;
        #12;
        check("reset_outputs", {8'd0, req_ready, rsp_valid, rsp_err, bus_strb, bus_ctl, bus_oe, bus_out},
              {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00});
        check("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // bus_ack while idle must not start anything.
        bus_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack", {29'd0, req_ready, bus_strb, rsp_valid}, {29'd0, 3'b100});
        end
        bus_ack = 1'b0;

        run_txn(1'b1, 16'h1234, 16'hA55A, 0, 0, 0, 0, 8'h00, 8'h00);
        run_txn(1'b0, 16'h00F0, 16'h0000, 3, 3, 3, 3, 8'hBE, 8'hEF);

        // Back-to-back reads with req_valid held high and ack tied high.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0A0B;
        bus_ack   = 1'b1;
        bus_in    = 8'h5C;
        @(negedge clk);
        check("b2b_first_beat", {13'd0, bus_strb, bus_ctl, bus_oe, bus_out}, {13'd0, beat_exp(2'b01, 8'h0A)});
        req_addr = 16'h0C0D;
        repeat (4) @(negedge clk);
        check("b2b_first_resp", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'h5C5C});
        @(negedge clk);
        check("b2b_idle_gap", {31'd0, req_ready}, 32'd1);
        bus_in = 8'hA7;
        @(negedge clk);
        check("b2b_second_accept", {13'd0, bus_strb, bus_ctl, bus_oe, bus_out}, {13'd0, beat_exp(2'b01, 8'h0C)});
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_second_resp", {15'd0, rsp_valid, rsp_rdata}, {15'd0, 1'b1, 16'hA7A7});
        @(negedge clk);
        check("b2b_done", {30'd0, req_ready, bus_strb}, {30'd0, 2'b10});
        bus_ack    = 1'b0;
        prev_rdata = 16'hA7A7;

        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom));
        end

`ifdef BRIDGE_TIMEOUT_EN
        // Ack never arrives: 15 cycles in ADDR_HI, then an error response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'($urandom);
        bus_ack   = 1'b0;
        seen      = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid && seen == 0) seen = k;
            if (seen != 0) break;
        end
        check("timeout_latency", 32'(seen), 32'd16);
        check("timeout_resp", {14'd0, rsp_valid, rsp_err, rsp_rdata}, {14'd0, 1'b1, 1'b1, 16'h0000});
        @(negedge clk);
        check("timeout_ready", {31'd0, req_ready}, 32'd1);
        prev_rdata = 16'h0000;

        // Ack in the 15th waiting cycle of a beat still completes it.
        run_txn(1'b0, 16'h4321, 16'h0000, 14, 0, 14, 14, 8'h6A, 8'h9D);
`endif

        // Reset pulse while a write-data beat is stalled.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h1357;
        req_wdata = 16'h2468;
        bus_ack   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_wr_hi", {13'd0, bus_strb, bus_ctl, bus_oe, bus_out}, {13'd0, beat_exp(2'b10, 8'h24)});
        bus_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {20'd0, bus_strb, req_ready, bus_ctl, bus_oe}, {20'd0, 1'b0, 1'b1, 2'b00, 8'h00});
        @(negedge clk);
        rst_n   = 1'b1;
        bus_ack = 1'b1;
        seen    = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);
        check("rdata_after_reset", {16'd0, rsp_rdata}, 32'd0);
        bus_ack    = 1'b0;
        prev_rdata = 16'h0000;

        run_txn(1'b0, 16'hFFFF, 16'h0000, 1, 0, 2, 1, 8'h81, 8'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
